// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared frame constants, FSM state type and baud helper for
//                the UART transmit path.
//  Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int   DATA_BITS     = 8;
    localparam int   STOP_BITS     = 1;
    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core_if
//  Description : Write-side handshake between the APB UART slave (master)
//                and the transmit core (slave).
//  Revision    : 1.0
// ============================================================================
interface uart_tx_core_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] din;
    logic                 wr_en;
    logic                 tx_busy;
    logic                 overflow;

    modport master (
        output din,
        output wr_en,
        input  tx_busy,
        input  overflow
    );

    modport slave (
        input  din,
        input  wr_en,
        output tx_busy,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous byte FIFO, 2**AW entries, head word presented
//                from the storage array at the read pointer.
//  Revision    : 1.0
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int AW = 3
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 push,
    input  wire logic [DATA_BITS-1:0] din,
    input  wire logic                 pop,
    output logic      [DATA_BITS-1:0] dout,
    output logic                      full,
    output logic                      empty,
    output logic      [AW:0]          count
);

    localparam int         C_DEPTH = 2 ** AW;
    localparam logic [AW:0] C_FULL = (AW + 1)'(C_DEPTH);

    logic [DATA_BITS-1:0] r_mem [C_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: only entries covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core
//  Description : Buffered 8N1 UART transmitter; FIFO-full back-pressures the
//                APB slave through tx_busy.
//  Revision    : 1.0
// ============================================================================
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 3
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    uart_tx_core_if.slave   wr_if,
    output logic            tx_idle,
    output logic            tx
);

    localparam int                CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int                C_BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [C_BAUD_W-1:0] C_BAUD_LAST = C_BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                C_IDX_W      = $clog2(DATA_BITS);
    localparam logic [C_IDX_W-1:0] C_DATA_LAST = C_IDX_W'(DATA_BITS - 1);
    localparam logic [C_IDX_W-1:0] C_STOP_LAST = C_IDX_W'(STOP_BITS - 1);

    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_dout;
    logic                 w_full;
    logic                 w_empty;
    logic [FIFO_AW:0]     w_count;

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [C_BAUD_W-1:0]  r_baud;
    logic [C_BAUD_W-1:0]  w_baud_next;
    logic [C_IDX_W-1:0]   r_bit_idx;
    logic [C_IDX_W-1:0]   w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_bit_end;

    // Writes are refused on the registered full flag even if a pop is due.
    assign w_push         = wr_if.wr_en && !w_full;
    assign wr_if.tx_busy  = w_full;
    assign wr_if.overflow = wr_if.wr_en && w_full;

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (wr_if.din),
        .pop     (w_pop),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_bit_end = (r_baud == C_BAUD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_dout;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == C_DATA_LAST) begin
                        w_bit_idx_next = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == C_STOP_LAST) begin
                        w_bit_idx_next = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The line level is decoded from the next state so tx leaves a flop.
    always_comb begin
        w_tx_next = TX_IDLE_LEVEL;
        unique case (w_state_next)
            START:   w_tx_next = ~TX_IDLE_LEVEL;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= TX_IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx      = r_tx;
    assign tx_idle = (w_count == '0) && (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_core
//  Description : Scoreboard bench for uart_tx_core at 10 clocks per bit.
//  Revision    : 1.0
// ============================================================================
module tb_uart_tx_core;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx_idle;
    logic tx;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_start = -1000;
    exp_t exp_q[$];

    uart_tx_core_if bus ();

    uart_tx_core #(
        .CLK_HZ  (1000000),
        .BAUD    (100000),
        .FIFO_AW (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_if   (bus),
        .tx_idle (tx_idle),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Drive one write for one cycle; the expected frame start is scheduled
    // as the later of push+2 and one frame pitch after the previous start.
    task automatic push(input logic [7:0] b, input bit accept, input bit score);
        int n;
        int s;
        n = cyc;
        bus.wr_en = 1'b1;
        bus.din   = b;
        @(negedge clk);
        check("push_tx_busy", bus.tx_busy, {31'd0, !accept});
        check("push_overflow", bus.overflow, {31'd0, !accept});
        if (accept && score) begin
            s = n + 2;
            if (last_start + 101 > s) s = last_start + 101;
            last_start = s;
            exp_q.push_back('{data: b, start: s});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_wr();
        bus.wr_en = 1'b0;
        bus.din   = 8'h00;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (!tx_idle && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_bound", {31'd0, tx_idle}, 32'd1);
    endtask

    // Monitor: decode each frame at bit centres and compare with the queue.
    initial begin : monitor
        logic [9:0] bits;
        int         st;
        bit         aborted;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset_n && tx === 1'b0) begin
                st      = cyc;
                aborted = 1'b0;
                bits    = '1;
                for (int k = 1; k <= 95; k++) begin
                    @(negedge clk);
                    if (!reset_n) aborted = 1'b1;
                    if (k % 10 == 5) bits[k / 10] = tx;
                end
                if (!aborted) begin
                    check("frame_start_bit", {31'd0, bits[0]}, 32'd0);
                    check("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: actual=%0h required=none", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", {24'd0, bits[8:1]}, {24'd0, e.data});
                        check("frame_start_cycle", st, e.start);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0;
        int bad;
        bus.wr_en = 1'b0;
        bus.din   = 8'h00;

        // Reset state
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_tx_after", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;

        // Single byte, with tx_idle timing
        c0 = cyc;
        push(8'hA5, 1'b1, 1'b1);
        release_wr();
        goto_cycle(c0 + 101);
        @(negedge clk);
        check("single_idle_c101", {31'd0, tx_idle}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_idle_c102", {31'd0, tx_idle}, 32'd1);
        wait_idle();

        // Burst of three
        push(8'h01, 1'b1, 1'b1);
        push(8'h02, 1'b1, 1'b1);
        push(8'h03, 1'b1, 1'b1);
        release_wr();
        wait_idle();

        // Fill to full, overflow, then write during the IDLE pop cycle
        c0 = cyc;
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 1'b1, 1'b1);
        push(8'h19, 1'b0, 1'b1);
        release_wr();
        @(negedge clk);
        check("overflow_one_cycle", {31'd0, bus.overflow}, 32'd0);
        check("full_holds_busy", {31'd0, bus.tx_busy}, 32'd1);
        goto_cycle(c0 + 102);
        push(8'h1A, 1'b0, 1'b1);
        push(8'h1B, 1'b1, 1'b1);
        release_wr();
        wait_idle();

        // Reset during DATA bit 3 of 8'hFF
        c0 = cyc;
        push(8'hFF, 1'b1, 1'b0);
        release_wr();
        goto_cycle(c0 + 45);
        @(negedge clk);
        check("pre_reset_bit3", {31'd0, tx}, 32'd1);
        check("pre_reset_not_idle", {31'd0, tx_idle}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        last_start = -1000;
        @(negedge clk);
        check("post_reset_idle", {31'd0, tx_idle}, 32'd1);
        check("post_reset_busy", {31'd0, bus.tx_busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
        end
        check("post_reset_line_high", bad, 0);
        @(posedge clk);
        #1;

        // Pointer wrap: 20 single bytes, one at a time
        for (int i = 0; i < 20; i++) begin
            push(8'(i), 1'b1, 1'b1);
            release_wr();
            wait_idle();
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Transmit serializer that sits directly downstream of the APB UART slave; it consumes the byte and write strobe that the slave produces on each APB write.
- Buffers bytes in a small FIFO and shifts them out as 8N1 frames, LSB first, on the tx line.
- Its tx_busy output drives the APB slave's PREADY directly: the APB bus stalls only while the FIFO is full.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division, so 434 at the defaults. CLKS_PER_BIT must be at least 2.
- FIFO_AW, 3, FIFO address width. Depth = 2**FIFO_AW, which is 8 entries.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- din  input  8  byte to transmit. Sampled when wr_en=1 and tx_busy=0.
- wr_en  input  1  write strobe, level-sensitive. Each cycle it is high with tx_busy=0 pushes one byte.
- tx_busy  output  1  FIFO full, derived from the registered count. The APB slave uses it as a write stall.
- tx_idle  output  1  high when the FIFO is empty and the FSM is in IDLE (all bytes sent).
- overflow  output  1  one-cycle pulse when wr_en=1 arrives while tx_busy=1; that byte is dropped.
- tx  output  1  serial line; idle level is high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, tx_busy=0, tx_idle=1, overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0; bit index = 0.
- FIFO:
  - Push when wr_en && !tx_busy. Pop when the FSM is in IDLE and count != 0.
  - Pointers are FIFO_AW bits wide and wrap modulo the depth. count is FIFO_AW+1 bits, range 0..depth.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full with a pop in the same cycle: tx_busy is still 1 from the registered count, so the write is refused and overflow pulses. No combinational bypass.
  - Empty with a push: the byte becomes visible to the FSM on the next cycle. No read-during-write forwarding.
- FSM states and transitions:
  - IDLE: tx=1. If count != 0, pop into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP; otherwise increment the index.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back bytes: IDLE lasts exactly 1 cycle before the next START. Frame pitch is 10*CLKS_PER_BIT+1 cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets on each bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- tx is driven from a flop (glitch-free). Latency: wr_en into an empty, idle core at cycle N gives pop at N+1 and tx falling at N+2.
- tx_idle = (count==0) && (state==IDLE), registered inputs only.
- Reset asserted mid-frame: the frame aborts immediately, tx returns high, and FIFO contents are discarded. No partial-frame resume after release.
- wr_en held high over several cycles pushes one byte per cycle (din may change every cycle). The APB slave is responsible for single-pulse writes.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - localparams DATA_BITS=8, STOP_BITS=1, TX_IDLE_LEVEL=1'b1;
  - a function clks_per_bit(CLK_HZ, BAUD).
- One sub-module, uart_tx_fifo: a synchronous FIFO with parameter AW, ports clk/reset_n/push/din/pop/dout/full/empty/count. Its dout is registered at the read pointer and valid while empty=0.
- The FSM and baud counter stay in uart_tx_core.

Test Plan (CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10):
- Single byte: push 8'hA5 at cycle 0 → tx low at cycle 2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles. tx_idle returns to 1 at cycle 102.
- Burst: push 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames with start edges spaced 101 cycles apart; tx_busy stays 0 throughout.
- Fill: push 9 bytes 8'h10..8'h18 on consecutive cycles while the first frame is in progress → first byte popped at cycle 1. Count reaches 8 after the 9th push, so tx_busy=1. A 10th push while full → overflow pulses 1 cycle and 8'h19 never appears on tx.
- Full with simultaneous pop: hold wr_en=1 with tx_busy=1 across an IDLE pop cycle → that write is refused (overflow=1). The next cycle tx_busy=0 and the write is accepted.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 8'hFF → tx=1 asynchronously. After release: tx_idle=1, count=0, tx stays high for 50 cycles.
- Pointer wrap: push and drain 20 bytes 8'h00..8'h13 one at a time → every decoded byte matches in order; tx_busy is never asserted.
